shift_sequencer: RTL and testbench

Command sequencer that sits directly upstream of the PE array and its side shift registers. On `start` it issues, in order, an optional load-flush, |dx| horizontal shifts, |dy| vertical shifts, one multiply and, optionally, the inverse shifts that restore the original alignment. It drives the shared `command_to_execute` / `shift_direction` / `image_to_shift` / `ack` bus. Every command is handshaked against the AND of all downstream `ready` lines.

---
 rtl/shift_sequencer.sv | 266 ++++++++++++++++++++++++++
 tb/tb_shift_sequencer.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_sequencer.sv
// shift_sequencer
// ---------------------------------------------------------------------------
// Command sequencer feeding the PE array and its side shift registers.
// On an accepted start it issues, in order: an optional load/flush, |dx|
// horizontal shifts, |dy| vertical shifts, one multiply and, optionally,
// the inverse vertical then horizontal shifts that restore alignment.
// Each command is presented for one cycle with ack=0 (ISSUE) and then held
// with ack=1 (WAIT) until every downstream ready line is high.
//
// Ports
//   CLK                 clock, all logic on the rising edge
//   reset               synchronous active-high reset
//   start               one-cycle request, honoured only while idle
//   dx, dy              signed offsets (two's complement), captured at start
//   load, restore       sequence options, captured at start
//   ready               downstream ready flags, ANDed together
//   command_to_execute  000 mul, 001 up, 010 down, 011 left, 100 right, 101 load
//   shift_direction     00 up, 01 down, 10 left, 11 right
//   image_to_shift      always 0 (only image A is shifted)
//   ack                 1 = hold/clear, 0 = execute presented command
//   busy                sequence in progress
//   done                one-cycle completion pulse
//   error               sticky timeout flag
// ---------------------------------------------------------------------------
module shift_sequencer #(
   parameter int OFFSET_W  = 6,
   parameter int NUM_READY = 5,
   parameter int TIMEOUT   = 255
) (
   input  logic                 CLK,
   input  logic                 reset,
   input  logic                 start,
   input  logic [OFFSET_W-1:0]  dx,
   input  logic [OFFSET_W-1:0]  dy,
   input  logic                 load,
   input  logic                 restore,
   input  logic [NUM_READY-1:0] ready,
   output logic [2:0]           command_to_execute,
   output logic [1:0]           shift_direction,
   output logic                 image_to_shift,
   output logic                 ack,
   output logic                 busy,
   output logic                 done,
   output logic                 error
);

   // Wait counter only needs to reach TIMEOUT-1.
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

   localparam logic [OFFSET_W-1:0] ONE_W = {{(OFFSET_W-1){1'b0}}, 1'b1};

   localparam logic [2:0] PH_LOAD   = 3'd0;
   localparam logic [2:0] PH_HORIZ  = 3'd1;
   localparam logic [2:0] PH_VERT   = 3'd2;
   localparam logic [2:0] PH_MULT   = 3'd3;
   localparam logic [2:0] PH_RVERT  = 3'd4;
   localparam logic [2:0] PH_RHORIZ = 3'd5;
   localparam logic [2:0] PH_NONE   = 3'd6;

   localparam logic [2:0] CMD_MUL   = 3'b000;
   localparam logic [2:0] CMD_UP    = 3'b001;
   localparam logic [2:0] CMD_DOWN  = 3'b010;
   localparam logic [2:0] CMD_LEFT  = 3'b011;
   localparam logic [2:0] CMD_RIGHT = 3'b100;
   localparam logic [2:0] CMD_LOAD  = 3'b101;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2
   } state_t;

   state_t              state_r;
   logic [2:0]          phase_r;
   logic [OFFSET_W-1:0] cnt_r;
   logic [OFFSET_W-1:0] mx_r;
   logic [OFFSET_W-1:0] my_r;
   logic                sx_r;
   logic                sy_r;
   logic                load_r;
   logic                restore_r;
   logic [TW-1:0]       wait_cnt_r;
   logic [2:0]          cmd_r;
   logic [1:0]          dir_r;
   logic                ack_r;
   logic                busy_r;
   logic                done_r;
   logic                error_r;

   logic [OFFSET_W-1:0] mx_in_s;
   logic [OFFSET_W-1:0] my_in_s;
   logic [5:0]          start_mask_s;
   logic [5:0]          run_mask_s;
   logic [2:0]          start_phase_s;
   logic [2:0]          next_phase_s;

   // Unsigned magnitude; the most negative value maps to 2^(OFFSET_W-1).
   function automatic logic [OFFSET_W-1:0] magnitude(input logic [OFFSET_W-1:0] v);
      return v[OFFSET_W-1] ? (~v + ONE_W) : v;
   endfunction

   // One bit per phase, set when that phase issues at least one command.
   function automatic logic [5:0] phase_mask(input logic [OFFSET_W-1:0] mx,
                                             input logic [OFFSET_W-1:0] my,
                                             input logic ld, input logic rs);
      return {rs & (|mx), rs & (|my), 1'b1, |my, |mx, ld};
   endfunction

   // Lowest non-empty phase at or after 'from', PH_NONE if none is left.
   function automatic logic [2:0] first_phase(input logic [5:0] mask, input logic [2:0] from);
      logic [2:0] r;
      r = PH_NONE;
      for (int i = 5; i >= 0; i--) begin
         r = ((i >= int'(from)) && mask[3'(i)]) ? 3'(i) : r;
      end
      return r;
   endfunction

   function automatic logic [OFFSET_W-1:0] count_of(input logic [2:0] ph,
                                                   input logic [OFFSET_W-1:0] mx,
                                                   input logic [OFFSET_W-1:0] my);
      case (ph)
         PH_LOAD:   count_of = ONE_W;
         PH_HORIZ:  count_of = mx;
         PH_VERT:   count_of = my;
         PH_MULT:   count_of = ONE_W;
         PH_RVERT:  count_of = my;
         PH_RHORIZ: count_of = mx;
         default:   count_of = {OFFSET_W{1'b0}};
      endcase
   endfunction

   // sx/sy are the offset sign bits (1 = negative).
   function automatic logic [2:0] cmd_of(input logic [2:0] ph, input logic sx, input logic sy);
      case (ph)
         PH_LOAD:   cmd_of = CMD_LOAD;
         PH_HORIZ:  cmd_of = sx ? CMD_LEFT  : CMD_RIGHT;
         PH_VERT:   cmd_of = sy ? CMD_DOWN  : CMD_UP;
         PH_MULT:   cmd_of = CMD_MUL;
         PH_RVERT:  cmd_of = sy ? CMD_UP    : CMD_DOWN;
         PH_RHORIZ: cmd_of = sx ? CMD_RIGHT : CMD_LEFT;
         default:   cmd_of = CMD_MUL;
      endcase
   endfunction

   // Direction is fixed per axis so the forward-side register captures on the
   // forward shifts and releases on the return shifts.
   function automatic logic [1:0] dir_of(input logic [2:0] ph, input logic sx, input logic sy);
      case (ph)
         PH_HORIZ, PH_RHORIZ: dir_of = sx ? 2'b10 : 2'b11;
         PH_VERT,  PH_RVERT:  dir_of = sy ? 2'b01 : 2'b00;
         default:             dir_of = 2'b00;
      endcase
   endfunction

   // Phase selection from the live inputs (at start) and captured values (running).
   always_comb begin
      mx_in_s       = magnitude(dx);
      my_in_s       = magnitude(dy);
      start_mask_s  = phase_mask(mx_in_s, my_in_s, load, restore);
      run_mask_s    = phase_mask(mx_r, my_r, load_r, restore_r);
      start_phase_s = first_phase(start_mask_s, 3'd0);
      next_phase_s  = first_phase(run_mask_s, phase_r + 3'd1);
   end

   // Sequencer FSM with all bus outputs registered.
   always_ff @(posedge CLK) begin
      if (reset) begin
         state_r    <= S_IDLE;
         phase_r    <= PH_LOAD;
         cnt_r      <= {OFFSET_W{1'b0}};
         mx_r       <= {OFFSET_W{1'b0}};
         my_r       <= {OFFSET_W{1'b0}};
         sx_r       <= 1'b0;
         sy_r       <= 1'b0;
         load_r     <= 1'b0;
         restore_r  <= 1'b0;
         wait_cnt_r <= {TW{1'b0}};
         cmd_r      <= CMD_MUL;
         dir_r      <= 2'b00;
         ack_r      <= 1'b1;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         error_r    <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state_r)
            S_IDLE: begin
               // The done cycle still counts as the tail of the old sequence.
               if (start && !done_r) begin
                  mx_r      <= mx_in_s;
                  my_r      <= my_in_s;
                  sx_r      <= dx[OFFSET_W-1];
                  sy_r      <= dy[OFFSET_W-1];
                  load_r    <= load;
                  restore_r <= restore;
                  phase_r   <= start_phase_s;
                  cnt_r     <= count_of(start_phase_s, mx_in_s, my_in_s);
                  cmd_r     <= cmd_of(start_phase_s, dx[OFFSET_W-1], dy[OFFSET_W-1]);
                  dir_r     <= dir_of(start_phase_s, dx[OFFSET_W-1], dy[OFFSET_W-1]);
                  ack_r     <= 1'b0;
                  busy_r    <= 1'b1;
                  error_r   <= 1'b0;
                  state_r   <= S_ISSUE;
               end else begin
                  state_r <= S_IDLE;
               end
            end
            S_ISSUE: begin
               ack_r      <= 1'b1;
               wait_cnt_r <= {TW{1'b0}};
               state_r    <= S_WAIT;
            end
            S_WAIT: begin
               if (&ready) begin
                  wait_cnt_r <= {TW{1'b0}};
                  if (cnt_r != ONE_W) begin
                     cnt_r   <= cnt_r - ONE_W;
                     ack_r   <= 1'b0;
                     state_r <= S_ISSUE;
                  end else if (next_phase_s != PH_NONE) begin
                     phase_r <= next_phase_s;
                     cnt_r   <= count_of(next_phase_s, mx_r, my_r);
                     cmd_r   <= cmd_of(next_phase_s, sx_r, sy_r);
                     dir_r   <= dir_of(next_phase_s, sx_r, sy_r);
                     ack_r   <= 1'b0;
                     state_r <= S_ISSUE;
                  end else begin
                     cmd_r   <= CMD_MUL;
                     dir_r   <= 2'b00;
                     busy_r  <= 1'b0;
                     done_r  <= 1'b1;
                     state_r <= S_IDLE;
                  end
               end else if ((TIMEOUT != 0) && (wait_cnt_r == TW'(TIMEOUT - 1))) begin
                  // Abandon the remaining commands.
                  cmd_r   <= CMD_MUL;
                  dir_r   <= 2'b00;
                  busy_r  <= 1'b0;
                  done_r  <= 1'b1;
                  error_r <= 1'b1;
                  state_r <= S_IDLE;
               end else begin
                  wait_cnt_r <= wait_cnt_r + TW'(1'b1);
               end
            end
            default: begin
               ack_r   <= 1'b1;
               busy_r  <= 1'b0;
               cmd_r   <= CMD_MUL;
               dir_r   <= 2'b00;
               state_r <= S_IDLE;
            end
         endcase
      end
   end

   assign command_to_execute = cmd_r;
   assign shift_direction    = dir_r;
   assign image_to_shift     = 1'b0;
   assign ack                = ack_r;
   assign busy               = busy_r;
   assign done               = done_r;
   assign error              = error_r;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: directed scenarios plus randomized
// sequences with a randomized-latency ready responder. The model turns each
// accepted start into a list of {command, direction} pairs and predicts when
// each command or the done pulse must appear from the responder latency.
module tb_shift_sequencer;

   localparam int OW = 6;
   localparam int NR = 5;
   localparam int TO = 4;

   logic          CLK;
   logic          reset;
   logic          start;
   logic [OW-1:0] dx;
   logic [OW-1:0] dy;
   logic          load;
   logic          restore;
   logic [NR-1:0] ready;
   logic [2:0]    command_to_execute;
   logic [1:0]    shift_direction;
   logic          image_to_shift;
   logic          ack;
   logic          busy;
   logic          done;
   logic          error;

   shift_sequencer #(.OFFSET_W(OW), .NUM_READY(NR), .TIMEOUT(TO)) dut (
      .CLK                (CLK),
      .reset              (reset),
      .start              (start),
      .dx                 (dx),
      .dy                 (dy),
      .load               (load),
      .restore            (restore),
      .ready              (ready),
      .command_to_execute (command_to_execute),
      .shift_direction    (shift_direction),
      .image_to_shift     (image_to_shift),
      .ack                (ack),
      .busy               (busy),
      .done               (done),
      .error              (error)
   );

   int checks = 0;
   int errors = 0;

   // model state
   int         cyc = 0;
   int         next_ev = 0;
   int         done_cyc = -1;
   int         issue_cnt = 0;
   int         obs_first = 0;
   int         obs_done = 0;
   int         dut_done_cnt = 0;
   bit         active = 1'b0;
   bit         tmo_pend = 1'b0;
   bit         stall = 1'b0;
   bit         rand_mode = 1'b0;
   logic [4:0] exp_q[$];
   logic [4:0] obs[$];
   logic [4:0] held = 5'b00000;

   // responder state
   int pend_d[NR];
   int cd[NR];
   int pend_maxd = 0;

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Expected {cmd[2:0], dir[1:0]} list for one sequence.
   function automatic void build_seq(input int dxv, input int dyv, input bit ld, input bit rs);
      int mx;
      int my;
      logic [4:0] h;
      logic [4:0] v;
      logic [4:0] rh;
      logic [4:0] rv;
      mx = (dxv < 0) ? -dxv : dxv;
      my = (dyv < 0) ? -dyv : dyv;
      h  = (dxv > 0) ? 5'b10011 : 5'b01110;  // right/11 : left/10
      rh = (dxv > 0) ? 5'b01111 : 5'b10010;  // left/11  : right/10
      v  = (dyv > 0) ? 5'b00100 : 5'b01001;  // up/00    : down/01
      rv = (dyv > 0) ? 5'b01000 : 5'b00101;  // down/00  : up/01
      exp_q.delete();
      if (ld) exp_q.push_back(5'b10100);
      for (int k = 0; k < mx; k++) exp_q.push_back(h);
      for (int k = 0; k < my; k++) exp_q.push_back(v);
      exp_q.push_back(5'b00000);
      if (rs) begin
         for (int k = 0; k < my; k++) exp_q.push_back(rv);
         for (int k = 0; k < mx; k++) exp_q.push_back(rh);
      end
   endfunction

   function automatic void draw_delays();
      pend_maxd = 0;
      for (int i = 0; i < NR; i++) begin
         pend_d[i] = rand_mode ? int'($urandom_range(0, 2)) : 0;
         if (pend_d[i] > pend_maxd) pend_maxd = pend_d[i];
      end
   endfunction

   // Downstream responder: after an ISSUE edge each ready bit rises after its
   // own delay; all bits drop once the full set has been seen.
   initial begin : responder
      logic s_ack;
      logic s_all;
      logic s_rst;
      ready = '0;
      for (int i = 0; i < NR; i++) cd[i] = 0;
      draw_delays();
      forever begin
         @(negedge CLK);
         s_ack = ack;
         s_all = &ready;
         s_rst = reset;
         @(posedge CLK);
         #1;
         if (s_rst) begin
            ready = '0;
            for (int i = 0; i < NR; i++) cd[i] = 0;
         end else if (s_ack === 1'b0) begin
            ready = '0;
            if (!stall) begin
               for (int i = 0; i < NR; i++) begin
                  cd[i] = pend_d[i];
                  if (pend_d[i] == 0) ready[i] = 1'b1;
               end
            end
            draw_delays();
         end else if (s_all) begin
            ready = '0;
         end else begin
            for (int i = 0; i < NR; i++) begin
               if (!ready[i] && cd[i] > 0) begin
                  cd[i]--;
                  if (cd[i] == 0) ready[i] = 1'b1;
               end
            end
         end
      end
   end

   // Compare process: checks every output on every cycle against the model.
   initial begin : compare
      logic [4:0] e;
      forever begin
         @(negedge CLK);
         cyc++;
         if (reset) begin
            active   = 1'b0;
            tmo_pend = 1'b0;
            exp_q.delete();
            done_cyc = -1;
         end else begin
            chk("image_to_shift", image_to_shift, 0);
            if (active && cyc == next_ev) begin
               if (exp_q.size() != 0 && !tmo_pend) begin
                  e = exp_q.pop_front();
                  held = e;
                  chk("issue_ack", ack, 0);
                  chk("issue_cmd", command_to_execute, e[4:2]);
                  chk("issue_dir", shift_direction, e[1:0]);
                  chk("issue_busy", busy, 1);
                  chk("issue_done", done, 0);
                  obs.push_back({command_to_execute, shift_direction});
                  issue_cnt++;
                  if (issue_cnt == 1) obs_first = cyc;
                  if (stall) begin
                     tmo_pend = 1'b1;
                     next_ev  = cyc + 1 + TO;
                  end else begin
                     next_ev = cyc + 2 + pend_maxd;
                  end
               end else begin
                  chk("done_pulse", done, 1);
                  chk("done_busy", busy, 0);
                  chk("done_ack", ack, 1);
                  chk("done_cmd", command_to_execute, 0);
                  chk("done_dir", shift_direction, 0);
                  chk("done_error", error, tmo_pend);
                  active   = 1'b0;
                  done_cyc = cyc;
                  obs_done = cyc;
                  tmo_pend = 1'b0;
                  exp_q.delete();
               end
            end else if (active) begin
               chk("wait_ack", ack, 1);
               chk("wait_busy", busy, 1);
               chk("wait_done", done, 0);
               chk("wait_cmd", command_to_execute, held[4:2]);
               chk("wait_dir", shift_direction, held[1:0]);
            end else begin
               chk("idle_ack", ack, 1);
               chk("idle_busy", busy, 0);
               chk("idle_done", done, 0);
               chk("idle_cmd", command_to_execute, 0);
               chk("idle_dir", shift_direction, 0);
            end
            if (done === 1'b1) dut_done_cnt++;
            // accepted start: not busy, not the done cycle
            if (start && !active && cyc != done_cyc) begin
               build_seq(int'($signed(dx)), int'($signed(dy)), load, restore);
               active    = 1'b1;
               next_ev   = cyc + 1;
               issue_cnt = 0;
               obs.delete();
            end
         end
      end
   end

   task automatic wait_idle();
      for (int k = 0; k < 2000; k++) begin
         if (!active) break;
         @(posedge CLK);
         #1;
      end
      if (active) begin
         checks++;
         errors++;
         $display("FAIL wait_idle: sequence still active after cycle budget");
      end
   endtask

   task automatic do_seq(input int dxv, input int dyv, input logic ld, input logic rs);
      dx      = OW'(dxv);
      dy      = OW'(dyv);
      load    = ld;
      restore = rs;
      start   = 1'b1;
      @(posedge CLK);
      #1;
      start = 1'b0;
      wait_idle();
   endtask

   task automatic chk_list(input string name, input logic [4:0] lit[$]);
      chk({name, "_len"}, obs.size(), lit.size());
      for (int i = 0; i < lit.size() && i < obs.size(); i++) begin
         chk({name, "_item"}, obs[i], lit[i]);
      end
   endtask

   initial begin : stimulus
      logic [4:0] lit[$];
      int n_left;
      reset   = 1'b1;
      start   = 1'b0;
      dx      = '0;
      dy      = '0;
      load    = 1'b0;
      restore = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      reset = 1'b0;

      // idle after reset
      repeat (10) @(posedge CLK);
      #1;
      chk("reset_ack", ack, 1);
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_error", error, 0);
      chk("reset_cmd", command_to_execute, 0);

      // dx=+2, dy=-1
      do_seq(2, -1, 1'b0, 1'b0);
      lit = '{5'b10011, 5'b10011, 5'b01001, 5'b00000};
      chk_list("seq_p2_m1", lit);
      chk("seq_p2_m1_latency", obs_done - obs_first, 8);

      // load + restore with no offsets
      dut_done_cnt = 0;
      do_seq(0, 0, 1'b1, 1'b1);
      lit = '{5'b10100, 5'b00000};
      chk_list("seq_load", lit);
      chk("seq_load_latency", obs_done - obs_first, 4);
      repeat (3) @(posedge CLK);
      #1;
      chk("seq_load_done_pulses", dut_done_cnt, 1);

      // dx=-3, dy=+1 with restore
      do_seq(-3, 1, 1'b0, 1'b1);
      lit = '{5'b01110, 5'b01110, 5'b01110, 5'b00100, 5'b00000,
              5'b01000, 5'b10010, 5'b10010, 5'b10010};
      chk_list("seq_restore", lit);
      chk("seq_restore_latency", obs_done - obs_first, 18);

      // timeout: ready never rises
      stall = 1'b1;
      do_seq(1, 1, 1'b0, 1'b0);
      chk("timeout_error", error, 1);
      chk("timeout_latency", obs_done - obs_first, TO + 1);
      chk("timeout_issued", obs.size(), 1);
      stall = 1'b0;
      do_seq(0, 0, 1'b0, 1'b0);
      chk("timeout_cleared", error, 0);

      // reset during the WAIT of the 2nd command
      dx = OW'(3); dy = '0; load = 1'b0; restore = 1'b0;
      start = 1'b1;
      @(posedge CLK);
      #1;
      start = 1'b0;
      for (int k = 0; k < 50 && issue_cnt < 2; k++) begin
         @(posedge CLK);
         #1;
      end
      chk("midreset_reached_2nd", issue_cnt, 2);
      reset = 1'b1;
      @(posedge CLK);
      #1;
      reset = 1'b0;
      chk("midreset_ack", ack, 1);
      chk("midreset_busy", busy, 0);
      chk("midreset_cmd", command_to_execute, 0);

      // dx=-32 with a start pulse while busy
      dx = OW'(-32); dy = '0;
      start = 1'b1;
      @(posedge CLK);
      #1;
      start = 1'b0;
      repeat (5) @(posedge CLK);
      #1;
      dx = OW'(5);
      start = 1'b1;
      @(posedge CLK);
      #1;
      start = 1'b0;
      wait_idle();
      n_left = 0;
      foreach (obs[i]) if (obs[i] == 5'b01110) n_left++;
      chk("dx_m32_total", obs.size(), 33);
      chk("dx_m32_left", n_left, 32);

      // start during the done cycle is ignored
      dx = OW'(1); dy = '0;
      start = 1'b1;
      @(posedge CLK);
      #1;
      start = 1'b0;
      for (int k = 0; k < 50 && done !== 1'b1; k++) begin
         @(posedge CLK);
         #1;
      end
      chk("donecycle_seen", done, 1);
      dx = OW'(2);
      start = 1'b1;
      @(posedge CLK);
      #1;
      start = 1'b0;
      chk("donecycle_start_ignored", busy, 0);
      repeat (2) @(posedge CLK);
      #1;

      // randomized sequences with random ready latency
      rand_mode = 1'b1;
      for (int t = 0; t < 20; t++) begin
         do_seq(int'($urandom_range(0, 63)) - 32, int'($urandom_range(0, 63)) - 32,
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         repeat (int'($urandom_range(0, 3))) @(posedge CLK);
         #1;
      end
      rand_mode = 1'b0;
      repeat (3) @(posedge CLK);
      #1;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
